// File: rtl/sonar_pkg.sv
// Shared sonar types: ping sequencer state encoding, default sample/TOF widths and saturating magnitude.
package sonar_pkg;

  localparam int SAMPLE_W = 21;
  localparam int TOF_W    = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_BLANK,
    S_LISTEN,
    S_REPORT,
    S_HOLDOFF
  } state_t;

  // |v| for a w-bit signed value carried sign-extended in 32 bits; the most negative code clips to 2^(w-1)-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/ping_sequencer_if.sv
// Control, sample-stream and report signals of one ping sequencer.
// master = controller/sample source side, slave = the sequencer.
interface ping_sequencer_if #(
  parameter int SAMPLE_W = sonar_pkg::SAMPLE_W,
  parameter int TOF_W    = sonar_pkg::TOF_W
);
  logic                       start;
  logic                       auto_mode;
  logic                       abort;
  logic [SAMPLE_W-2:0]        threshold;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_data;
  logic                       tx_drive;
  logic                       tx_active;
  logic                       rx_window;
  logic                       busy;
  logic                       done;
  logic                       echo_hit;
  logic [TOF_W-1:0]           echo_tof;
  logic [SAMPLE_W-2:0]        echo_peak;

  modport master (
    output start, auto_mode, abort, threshold, sample_valid, sample_data,
    input  tx_drive, tx_active, rx_window, busy, done, echo_hit, echo_tof, echo_peak
  );

  modport slave (
    input  start, auto_mode, abort, threshold, sample_valid, sample_data,
    output tx_drive, tx_active, rx_window, busy, done, echo_hit, echo_tof, echo_peak
  );
endinterface

// File: rtl/tone_gen.sv
// Gated square-wave burst: BURST_CYCLES periods of 2*HALF_PERIOD clks, high half first, from the first enabled cycle.
// burst_done is high in the last cycle of the last period; dropping en resets the divider at once.
module tone_gen #(
  parameter int HALF_PERIOD  = 600,
  parameter int BURST_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tx_drive,
  output logic burst_done
);
  localparam int DW = $clog2(HALF_PERIOD + 1);
  localparam int PW = $clog2(BURST_CYCLES + 1);

  logic [DW-1:0] r_div;
  logic          r_phase;
  logic [PW-1:0] r_per;
  logic          w_half_end;

  assign w_half_end = (r_div == DW'(HALF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_per   <= '0;
    end else if (w_half_end) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
      if (r_phase) r_per <= r_per + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign tx_drive   = en && !r_phase;
  assign burst_done = en && w_half_end && r_phase && (r_per == PW'(BURST_CYCLES - 1));
endmodule

// File: rtl/ping_sequencer.sv
// One sonar ping: TX burst, blanking, listen window with echo confirm, one-cycle report, optional auto-repeat.
// TX starts the edge after start; abort returns to IDLE on the next edge; start while busy is dropped.
module ping_sequencer #(
  parameter int HALF_PERIOD  = 600,
  parameter int BURST_CYCLES = 8,
  parameter int BLANK_CLKS   = 24000,
  parameter int LISTEN_CLKS  = 1440000,
  parameter int HOLDOFF_CLKS = 480000,
  parameter int SAMPLE_W     = sonar_pkg::SAMPLE_W,
  parameter int CONFIRM      = 3,
  parameter int TOF_W        = sonar_pkg::TOF_W
) (
  input logic             clk,
  input logic             reset,
  ping_sequencer_if.slave bus
);
  import sonar_pkg::*;

  localparam int RW = $clog2(CONFIRM + 1);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_cnt;
  logic [TOF_W-1:0]    r_tof;
  logic [TOF_W-1:0]    r_run_tof;
  logic [TOF_W-1:0]    r_echo_tof;
  logic [RW-1:0]       r_run;
  logic                r_hit;
  logic [SAMPLE_W-2:0] r_peak;
  logic [SAMPLE_W-2:0] w_mag;
  logic                w_qual;
  logic                w_enter_tx;
  logic                w_burst_done;
  logic                w_tone_drive;

  tone_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .BURST_CYCLES(BURST_CYCLES)
  ) u_tone (
    .clk       (clk),
    .reset     (reset),
    .en        (r_state == S_TX),
    .tx_drive  (w_tone_drive),
    .burst_done(w_burst_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_TX;
      S_TX:      if (w_burst_done) w_next = S_BLANK;
      S_BLANK:   if (r_cnt == 32'(BLANK_CLKS - 1)) w_next = S_LISTEN;
      S_LISTEN:  if (r_cnt == 32'(LISTEN_CLKS - 1)) w_next = S_REPORT;
      S_REPORT:  w_next = bus.auto_mode ? S_HOLDOFF : S_IDLE;
      S_HOLDOFF: if (r_cnt == 32'(HOLDOFF_CLKS - 1)) w_next = S_TX;
      default:   w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  assign w_enter_tx = (w_next == S_TX) && (r_state != S_TX);

  // r_cnt restarts at 0 on every state change, so it is the dwell time in the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
    end
  end

  // Time of flight counts from the first TX cycle (value 0) and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE || w_enter_tx) r_tof <= '0;
    else if (r_tof != '1) r_tof <= r_tof + 1'b1;
  end

  assign w_mag  = (SAMPLE_W-1)'(sat_abs(32'(bus.sample_data), SAMPLE_W));
  assign w_qual = (w_mag >= bus.threshold);

  always_ff @(posedge clk) begin
    if (reset || w_enter_tx) begin
      r_hit      <= 1'b0;
      r_echo_tof <= '0;
      r_peak     <= '0;
      r_run      <= '0;
      r_run_tof  <= '0;
    end else if (r_state == S_LISTEN && bus.sample_valid) begin
      if (w_mag > r_peak) r_peak <= w_mag;
      if (w_qual) begin
        if (r_run == '0) r_run_tof <= r_tof;
        if (r_run != RW'(CONFIRM)) r_run <= r_run + 1'b1;
        if (!r_hit && r_run == RW'(CONFIRM - 1)) begin
          r_hit      <= 1'b1;
          r_echo_tof <= (r_run == '0) ? r_tof : r_run_tof;
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  assign bus.tx_drive  = w_tone_drive;
  assign bus.tx_active = (r_state == S_TX);
  assign bus.rx_window = (r_state == S_LISTEN);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_REPORT);
  assign bus.echo_hit  = r_hit;
  assign bus.echo_tof  = r_echo_tof;
  assign bus.echo_peak = r_peak;
endmodule
